// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined adder/subtractor.
//   - Bit positions of the per-beat operation control word (sub/signed/sat).
//   - ctrl_t: the packed control word carried down the pipeline.
//   - sat_max/sat_min: saturation limits for a given result width, returned
//     right-aligned in 32 bits. The caller truncates to its own width.
// -----------------------------------------------------------------------------
package addsub_pkg;

  localparam int CTRL_W      = 3;
  localparam int CTRL_SUB    = 0;  // 1 = A-B, 0 = A+B
  localparam int CTRL_SIGNED = 1;  // 1 = two's-complement operands/result
  localparam int CTRL_SAT    = 2;  // 1 = clamp on overflow, 0 = wrap

  typedef logic [CTRL_W-1:0] ctrl_t;

  // Largest representable result: 0111..1 when signed, 1111..1 when unsigned.
  function automatic logic [31:0] sat_max(input int width, input logic is_signed);
    logic [31:0] ones;
    ones = '1;
    return is_signed ? (ones >> (33 - width)) : (ones >> (32 - width));
  endfunction

  // Smallest representable result: 1000..0 when signed, 0 when unsigned.
  function automatic logic [31:0] sat_min(input int width, input logic is_signed);
    return is_signed ? (32'd1 << (width - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/addsub_if.sv
// -----------------------------------------------------------------------------
// addsub_if
// Operand/result bus of addsub_pipe.
//
// Handshake: on both the operand side (in_valid/in_ready) and the result side
// (out_valid/out_ready) a beat transfers on a rising edge where valid and
// ready are both 1. A producer never waits for ready before raising valid.
// Once out_valid is 1, out_res and out_ovf hold until the beat transfers.
//
// Signals:
//   in_valid, in_ready          operand beat handshake
//   op_a, op_b                  operands (WIDTH bits)
//   op_sub, op_signed, op_sat   per-beat operation select
//   out_valid, out_ready        result beat handshake
//   out_res, out_ovf            result and its overflow flag
//   ovf_sticky, ovf_clr         sticky overflow status and its clear
// Modports: master = producer/consumer side, slave = addsub_pipe.
// -----------------------------------------------------------------------------
interface addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             op_signed;
  logic             op_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_ovf;
  logic             ovf_sticky;
  logic             ovf_clr;

  modport master (
    output in_valid, op_a, op_b, op_sub, op_signed, op_sat, out_ready, ovf_clr,
    input  in_ready, out_valid, out_res, out_ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, op_signed, op_sat, out_ready, ovf_clr,
    output in_ready, out_valid, out_res, out_ovf, ovf_sticky
  );
endinterface

// File: rtl/addsub_core.sv
// -----------------------------------------------------------------------------
// addsub_core
// Combinational add/subtract with overflow detection and result selection.
// Ports:
//   i_ext_a, i_ext_b  operands already extended to WIDTH+2 bits
//   i_ctrl            operation control word (addsub_pkg CTRL_* bits)
//   o_res             wrapped or saturated WIDTH-bit result
//   o_ovf             overflow/underflow for this result, independent of sat
// -----------------------------------------------------------------------------
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SAT_EN = 1
) (
  input  logic [WIDTH+1:0] i_ext_a,
  input  logic [WIDTH+1:0] i_ext_b,
  input  ctrl_t            i_ctrl,
  output logic [WIDTH-1:0] o_res,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH, 1'b1));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH, 1'b1));
  localparam logic [WIDTH-1:0] UMAX = WIDTH'(sat_max(WIDTH, 1'b0));

  logic             w_sub;
  logic             w_sgn;
  logic             w_sat;
  logic [WIDTH+1:0] w_b_op;
  logic [WIDTH+1:0] w_exact;
  logic [2:0]       w_top;

  assign w_sub = i_ctrl[CTRL_SUB];
  assign w_sgn = i_ctrl[CTRL_SIGNED];
  assign w_sat = i_ctrl[CTRL_SAT];

  // Two guard bits make the sum exact for every operand pair and mode.
  assign w_b_op  = w_sub ? ~i_ext_b : i_ext_b;
  assign w_exact = i_ext_a + w_b_op + {{(WIDTH+1){1'b0}}, w_sub};

  // Signed result fits in WIDTH bits only if the top three bits agree.
  assign w_top = w_exact[WIDTH+1:WIDTH-1];

  always_comb begin
    o_ovf = 1'b0;
    o_res = w_exact[WIDTH-1:0];
    if (w_sgn) begin
      o_ovf = !((w_top == 3'b000) || (w_top == 3'b111));
    end else begin
      // Unsigned: sub borrows when the exact value is negative; add carries
      // into bit WIDTH.
      o_ovf = w_sub ? w_exact[WIDTH+1] : w_exact[WIDTH];
    end
    if ((SAT_EN != 0) && w_sat && o_ovf) begin
      if (w_sgn) begin
        o_res = w_exact[WIDTH+1] ? SMIN : SMAX;
      end else begin
        o_res = w_sub ? '0 : UMAX;
      end
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
// Two-stage pipelined adder/subtractor with valid/ready on both sides.
//   S1 holds the accepted operands and control. S2 holds the finished result,
//   which drives the output bus directly.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; drops all in-flight beats
//   bus   addsub_if slave: operand beats in, result beats out, sticky flag
// -----------------------------------------------------------------------------
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SAT_EN = 1
) (
  input  logic     clk,
  input  logic     rst,
  addsub_if.slave  bus
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  ctrl_t            r_s1_ctrl;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_res;
  logic             r_s2_ovf;
  logic             r_sticky;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH+1:0] w_ext_a;
  logic [WIDTH+1:0] w_ext_b;
  logic [WIDTH-1:0] w_core_res;
  logic             w_core_ovf;

  // Ready propagates combinationally so a full pipe streams without bubbles.
  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_in_xfer  = bus.in_valid && w_s1_adv;
  assign w_out_xfer = r_s2_valid && bus.out_ready;

  assign w_ext_a = r_s1_ctrl[CTRL_SIGNED] ? {{2{r_s1_a[WIDTH-1]}}, r_s1_a}
                                          : {2'b00, r_s1_a};
  assign w_ext_b = r_s1_ctrl[CTRL_SIGNED] ? {{2{r_s1_b[WIDTH-1]}}, r_s1_b}
                                          : {2'b00, r_s1_b};

  addsub_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_core (
    .i_ext_a (w_ext_a),
    .i_ext_b (w_ext_b),
    .i_ctrl  (r_s1_ctrl),
    .o_res   (w_core_res),
    .o_ovf   (w_core_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_ctrl  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_ovf   <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_in_xfer) begin
        r_s1_a    <= bus.op_a;
        r_s1_b    <= bus.op_b;
        r_s1_ctrl <= {bus.op_sat, bus.op_signed, bus.op_sub};
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      // Result registers only load with a real beat, so a stalled or empty
      // slot keeps its last value.
      if (w_s2_adv && r_s1_valid) begin
        r_s2_res <= w_core_res;
        r_s2_ovf <= w_core_ovf;
      end
      // A delivered overflow beat outranks a same-cycle clear.
      if (w_out_xfer && r_s2_ovf) begin
        r_sticky <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_s1_adv;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_res    = r_s2_res;
  assign bus.out_ovf    = r_s2_ovf;
  assign bus.ovf_sticky = r_sticky;

endmodule

// File: tb/tb_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_addsub_pipe
// Bench for addsub_pipe at WIDTH=4, SAT_EN=1: directed vector table, back-
// pressure, sticky flag and mid-stream reset sequences, then a randomized run
// scored against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_addsub_pipe;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addsub_if #(.WIDTH(W)) bus ();

  addsub_pipe #(
    .WIDTH  (W),
    .SAT_EN (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- bookkeeping ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_out    = 0;
  logic       saw_stall = 1'b0;
  logic       m_sticky  = 1'b0;
  logic       hold      = 1'b0;
  logic [W-1:0] held_res;
  logic       held_ovf;
  logic [W:0] exp_q[$];   // {ovf, res} per beat in flight
  logic [W:0] mon_e;
  logic       mon_xo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then range check and clamp.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub, input logic sgn, input logic sat);
    int va, vb, ex, lo, hi;
    logic ovf;
    logic [W-1:0] r;
    if (sgn) begin
      va = int'($signed(a));
      vb = int'($signed(b));
      lo = -(1 << (W - 1));
      hi = (1 << (W - 1)) - 1;
    end else begin
      va = int'(a);
      vb = int'(b);
      lo = 0;
      hi = (1 << W) - 1;
    end
    ex  = sub ? (va - vb) : (va + vb);
    ovf = (ex < lo) || (ex > hi);
    if (ovf && sat) r = (ex < lo) ? lo[W-1:0] : hi[W-1:0];
    else            r = ex[W-1:0];
    return {ovf, r};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_sticky = 1'b0;
      hold     = 1'b0;
    end else begin
      mon_xo = 1'b0;
      check("sticky", bus.ovf_sticky, m_sticky);
      // Pipeline holds two beats; it only refuses input when full and stalled.
      check("in_ready", bus.in_ready, (exp_q.size() < 2) || bus.out_ready);
      if (!bus.in_ready) saw_stall = 1'b1;
      if (hold) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_res", bus.out_res, held_res);
        check("stall_ovf", bus.out_ovf, held_ovf);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL spurious_out: out_valid=1 res=%0h with no beat expected at %0t",
                   bus.out_res, $time);
        end else if (bus.out_ready) begin
          mon_e = exp_q.pop_front();
          check("sb_res", bus.out_res, mon_e[W-1:0]);
          check("sb_ovf", bus.out_ovf, mon_e[W]);
          mon_xo = mon_e[W];
          n_out++;
        end
      end
      hold     = bus.out_valid && !bus.out_ready;
      held_res = bus.out_res;
      held_ovf = bus.out_ovf;
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.op_a, bus.op_b, bus.op_sub, bus.op_signed, bus.op_sat));
      m_sticky = mon_xo ? 1'b1 : (bus.ovf_clr ? 1'b0 : m_sticky);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic sgn, input logic sat);
    logic ok;
    int   t;
    t = 0;
    bus.in_valid  = 1'b1;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.op_sub    = sub;
    bus.op_signed = sgn;
    bus.op_sat    = sat;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      t++;
    end while (!ok && t < 50);
    #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d beats still outstanding", exp_q.size());
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = '0;
      1:       v = '1;
      2:       v = W'(1 << (W - 1));
      3:       v = W'((1 << (W - 1)) - 1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         sgn;
    logic         sat;
    logic [W-1:0] res;
    logic         ovf;
    string        name;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];
  vec_t v;
  int   n0;
  logic took;

  initial begin
    //           a      b    sub   sgn   sat   res       ovf
    vecs[0]  = '{4'd7,  4'd1,  1'b0, 1'b1, 1'b1, 4'b0111, 1'b1, "s_7p1_sat"};
    vecs[1]  = '{4'd7,  4'd1,  1'b0, 1'b1, 1'b0, 4'b1000, 1'b1, "s_7p1_wrap"};
    vecs[2]  = '{4'd8,  4'd1,  1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, "s_m8m1_sat"};
    vecs[3]  = '{4'd13, 4'd11, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, "s_m3mm5"};
    vecs[4]  = '{4'd3,  4'd5,  1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, "u_3m5_sat"};
    vecs[5]  = '{4'd3,  4'd5,  1'b1, 1'b0, 1'b0, 4'b1110, 1'b1, "u_3m5_wrap"};
    vecs[6]  = '{4'd15, 4'd1,  1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, "u_15p1_sat"};
    vecs[7]  = '{4'd9,  4'd6,  1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, "u_9p6"};
    vecs[8]  = '{4'd8,  4'd8,  1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, "s_m8pm8_wrap"};
    vecs[9]  = '{4'd8,  4'd8,  1'b0, 1'b1, 1'b1, 4'b1000, 1'b1, "s_m8pm8_sat"};
    vecs[10] = '{4'd7,  4'd8,  1'b1, 1'b1, 1'b1, 4'b0111, 1'b1, "s_7mm8_sat"};
    vecs[11] = '{4'd0,  4'd8,  1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, "s_0mm8_wrap"};
    vecs[12] = '{4'd15, 4'd15, 1'b0, 1'b1, 1'b1, 4'b1110, 1'b0, "s_m1pm1"};
    vecs[13] = '{4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b1, "u_15p15_wrap"};
    vecs[14] = '{4'd0,  4'd15, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, "u_0m15_sat"};
    vecs[15] = '{4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, "u_15m15"};
    vecs[16] = '{4'd7,  4'd7,  1'b0, 1'b1, 1'b0, 4'b1110, 1'b1, "s_7p7_wrap"};
    vecs[17] = '{4'd0,  4'd0,  1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, "s_0m0"};
    vecs[18] = '{4'd8,  4'd7,  1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, "s_m8m7_wrap"};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sub    = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_sat    = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_res", bus.out_res, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check("rst_sticky", bus.ovf_sticky, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Directed table: one beat at a time, latency checked on each
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      send_beat(v.a, v.b, v.sub, v.sgn, v.sat);
      check({v.name, "_lat1"}, bus.out_valid, 0);
      @(posedge clk);
      #1;
      check({v.name, "_valid"}, bus.out_valid, 1);
      check({v.name, "_res"}, bus.out_res, v.res);
      check({v.name, "_ovf"}, bus.out_ovf, v.ovf);
      @(posedge clk);
      #1;
    end

    // Back-pressure: 6 beats, out_ready low for cycles 3..6
    saw_stall = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int c = 0; c < 12; c++) begin
          bus.out_ready = !(c >= 3 && c <= 6);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 6; k++)
          send_beat(pick(), pick(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    join
    drain();
    check("bp_count", n_out - n0, 6);
    check("bp_in_ready_dropped", saw_stall, 1);

    // Sticky flag: set, clear alone, set wins over same-cycle clear
    bus.out_ready = 1'b1;
    send_beat(4'd7, 4'd1, 1'b0, 1'b1, 1'b1);
    drain();
    check("sticky_set", bus.ovf_sticky, 1);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    check("sticky_clr", bus.ovf_sticky, 0);
    send_beat(4'd7, 4'd1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("sticky_beat_valid", bus.out_valid, 1);
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr = 1'b0;
    check("sticky_set_wins", bus.ovf_sticky, 1);

    // Reset mid-stream with both stages full
    bus.out_ready = 1'b0;
    send_beat(4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
    send_beat(4'd7, 4'd7, 1'b0, 1'b1, 1'b1);
    check("mid_full_valid", bus.out_valid, 1);
    check("mid_full_in_ready", bus.in_ready, 0);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.op_a     = 4'd5;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_sticky", bus.ovf_sticky, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    n0 = n_out;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_stale", n_out - n0, 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (!bus.in_valid || took) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.op_a      = pick();
        bus.op_b      = pick();
        bus.op_sub    = 1'($urandom_range(0, 1));
        bus.op_signed = 1'($urandom_range(0, 1));
        bus.op_sat    = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.ovf_clr   = ($urandom_range(0, 7) == 0);
    end
    bus.in_valid  = 1'b0;
    bus.ovf_clr   = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
